icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the CPU's instruction-fetch port and the word-wide main-memory port.
- On a hit, it returns the instruction combinationally in the same cycle.
- On a miss, it raises a stall request and refills the whole line with a req/ack handshake.
- Once the line is valid, it releases the stall.
- It provides fence.i-style whole-cache invalidation and free-running hit/miss counters.

## Interface
Parameters:
- `LINE_WORDS`, default 4: 32-bit words per line; power of two, at least 2.
- `SETS`, default 64: number of lines; power of two.
- `ADDR_WIDTH`, default 32: byte-address width.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-low reset.
- `cpu_ce_i`  in  1: fetch request valid.
- `cpu_addr_i`  in  ADDR_WIDTH: fetch byte address; bits [1:0] ignored.
- `cpu_data_o`  out  32: instruction word, meaningful only when `cpu_valid_o`=1.
- `cpu_valid_o`  out  1: hit this cycle.
- `stall_req_o`  out  1: drives the pipeline IF stall request.
- `flush_i`  in  1: invalidate all lines.
- `mem_req_o`  out  1: word read request.
- `mem_addr_o`  out  ADDR_WIDTH: word-aligned refill address.
- `mem_data_i`  in  32: read data, valid when `mem_ack_i`=1.
- `mem_ack_i`  in  1: request accepted and data returned in the same cycle.
- `hit_cnt_o`  out  32: hit counter.
- `miss_cnt_o`  out  32: miss counter.

## Operation
Address split, with OFF = log2(LINE_WORDS) and IDX = log2(SETS):
- word offset = addr[OFF+1:2]
- index = addr[OFF+IDX+1:OFF+2]
- tag = addr[ADDR_WIDTH-1:OFF+IDX+2]
- Defaults give offset [3:2], index [9:4], tag [31:10].

Storage: a valid bit and a tag per set, plus a data array, all in flops.

FSM states are IDLE and REFILL.

IDLE:
- Hit condition: `cpu_ce_i` & valid[idx] & tag match.
- On a hit: `cpu_valid_o`=1, `cpu_data_o`=data[idx][off], `stall_req_o`=0, and `hit_cnt_o` increments.
- On a miss with `cpu_ce_i`=1: `stall_req_o`=1 in that same cycle, `miss_cnt_o` increments, the tag and index are latched, and the next state is REFILL with word counter = 0.
- With `cpu_ce_i`=0: no lookup, all CPU outputs are 0, and no counter changes.

REFILL:
- `mem_req_o`=1 with `mem_addr_o`={latched tag, latched index, counter, 2'b00}, held stable until `mem_ack_i`.
- On each ack, `mem_data_i` is written into data[idx][counter] and the counter increments.
- On the ack with counter = LINE_WORDS-1: tag[idx] is written, valid[idx] is set unless a flush was seen during this refill, and the next state is IDLE.
- `stall_req_o`=1 and `cpu_valid_o`=0 throughout REFILL.

Flush:
- A flush in IDLE clears every valid bit at the clock edge.
- A flush in REFILL also clears every valid bit and sets a pending flag. The refill then finishes its memory transactions but leaves the line invalid.
- If `flush_i` and a lookup happen in the same IDLE cycle, the lookup uses the pre-flush valid bits. The hit is reported in that cycle, and if it is a miss, the refill starts.

Address changes during REFILL:
- A change of `cpu_addr_i` has no effect. The refill completes for the latched address.
- In IDLE, the new address is then looked up and may miss again.

Counters are 32-bit and wrap from 0xFFFF_FFFF to 0.

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE, all valid bits 0, word counter 0, pending-flush flag 0;
  - `mem_req_o`=0, `mem_addr_o`=0, `cpu_valid_o`=0, `cpu_data_o`=0, `stall_req_o`=0;
  - both counters 0.
- Data and tag arrays are not reset.
- Reset during REFILL drops `mem_req_o` immediately and abandons the transaction.
- Hit latency: 0 cycles, combinational from `cpu_addr_i`.
- Miss penalty:
  - a miss in cycle T puts the FSM in REFILL from T+1;
  - with `mem_ack_i` held at 1, the last word is written at the edge ending T+LINE_WORDS;
  - the hit is reported in T+LINE_WORDS+1.
- With zero ack wait, the default configuration holds `stall_req_o` high for LINE_WORDS+1 = 5 cycles.
- Each cycle of ack delay extends the stall by one cycle.
- `mem_req_o` never deasserts before its ack (except on reset); at most one request is outstanding.

## Structure
- Shared package `icache_pkg`:
  - state enum `{IDLE, REFILL}`;
  - localparams OFF_W, IDX_W, TAG_W derived from the parameters;
  - a function extracting the tag/index/offset fields.
- Sub-module `icache_refill_ctrl`: the FSM, word counter, mem handshake and pending-flush flag.
- Top `icache`: the arrays, hit logic and counters.

## Test plan
- Cold miss, defaults, zero-wait memory:
  - stimulus: `rst` release, ce=1, addr 0x0000_0104;
  - expect mem reads at 0x100, 0x104, 0x108, 0x10C in order;
  - stall for 5 cycles, then `cpu_valid_o`=1 with the word returned for 0x104;
  - hit_cnt=1, miss_cnt=1.
- Same line, then conflict:
  - fetch 0x108 → hit in 0 cycles, no mem_req;
  - fetch 0x0000_0500 (same index 0x10, different tag) → miss;
  - after the refill, 0x104 misses again.
- Memory wait states: ack delayed 3 cycles per word → `mem_addr_o` held stable, stall lasts 4×4+1 = 17 cycles, data correct.
- Flush mid-refill:
  - stimulus: flush_i pulsed in refill cycle 2 for line 0x100;
  - expect the refill to complete all 4 reads;
  - the next fetch of 0x100 misses again (miss_cnt=2).
- Reset mid-refill: deassert `rst` after the second ack → `mem_req_o`=0 asynchronously; after release, a fetch of 0x100 misses.
- ce low: ce=0 with any address → no mem_req, `stall_req_o`=0, counters unchanged.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: definitions shared by the instruction cache and its refill
// controller.
//   state_t             refill FSM states (IDLE, REFILL)
//   OFF_W/IDX_W/TAG_W   address field widths for the default geometry
//                       (4 words/line, 64 sets, 32-bit byte address)
//   addr_field()        extracts a bit field (tag, index or word offset)
//                       from a zero-extended byte address
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam int LINE_WORDS_DEF = 4;
  localparam int SETS_DEF       = 64;
  localparam int ADDR_WIDTH_DEF = 32;

  localparam int OFF_W = $clog2(LINE_WORDS_DEF);
  localparam int IDX_W = $clog2(SETS_DEF);
  localparam int TAG_W = ADDR_WIDTH_DEF - OFF_W - IDX_W - 2;

  // Returns addr[lsb +: width]. The caller narrows the result with a
  // size cast, so one helper serves every field and every geometry.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int          lsb,
                                             input int          width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss-handling FSM of the instruction cache.
// Latches the missing tag/index, walks the line word by word over the
// req/ack memory port and tells the top when to write data, tag and valid.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start                lookup missed this cycle (only honoured in IDLE)
//   miss_tag, miss_idx   tag and index of the missing address
//   flush                whole-cache invalidate request
//   mem_ack              memory accepted the request and returned data
//   busy                 FSM is in REFILL
//   mem_req, mem_addr    registered word read request / word-aligned address
//   wr_en                write mem data into data[fill_idx][fill_word]
//   fill_done            last word of the line is being written
//   set_valid            fill_done and no flush seen during this refill
//   fill_idx, fill_tag   latched index / tag of the line being refilled
//   fill_word            word counter within the line
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-$clog2(SETS)-3:0] miss_tag,
  input  logic [$clog2(SETS)-1:0]                            miss_idx,
  input  logic                                               flush,
  input  logic                                               mem_ack,
  output logic                                               busy,
  output logic                                               mem_req,
  output logic [ADDR_WIDTH-1:0]                              mem_addr,
  output logic                                               wr_en,
  output logic                                               fill_done,
  output logic                                               set_valid,
  output logic [$clog2(SETS)-1:0]                            fill_idx,
  output logic [ADDR_WIDTH-$clog2(LINE_WORDS)-$clog2(SETS)-3:0] fill_tag,
  output logic [$clog2(LINE_WORDS)-1:0]                      fill_word
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDR_WIDTH - OFF_BITS - IDX_BITS - 2;
  localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

  state_t              state_q;
  logic [OFF_BITS-1:0] word_q;
  logic [OFF_BITS-1:0] next_word;
  logic [TAG_BITS-1:0] tag_q;
  logic [IDX_BITS-1:0] idx_q;
  logic                pend_flush_q;
  logic                ack_seen;
  logic                last_ack;

  assign next_word = word_q + 1'b1;
  assign ack_seen  = (state_q == REFILL) && mem_ack;
  assign last_ack  = ack_seen && (word_q == LAST_WORD);

  assign busy      = (state_q == REFILL);
  assign wr_en     = ack_seen;
  assign fill_done = last_ack;
  // A flush arriving on the very last ack must also keep the line invalid,
  // since the pending flag would only be set at that same edge.
  assign set_valid = last_ack && !pend_flush_q && !flush;
  assign fill_idx  = idx_q;
  assign fill_tag  = tag_q;
  assign fill_word = word_q;

  // Refill FSM. mem_req/mem_addr are registered so the request stays
  // stable until acked; reset drops the request at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      pend_flush_q <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= REFILL;
            tag_q        <= miss_tag;
            idx_q        <= miss_idx;
            word_q       <= '0;
            pend_flush_q <= 1'b0;
            mem_req      <= 1'b1;
            mem_addr     <= {miss_tag, miss_idx, {OFF_BITS{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (flush) begin
            pend_flush_q <= 1'b1;
          end
          if (mem_ack) begin
            if (word_q == LAST_WORD) begin
              state_q      <= IDLE;
              word_q       <= '0;
              pend_flush_q <= 1'b0;
              mem_req      <= 1'b0;
              mem_addr     <= '0;
            end else begin
              word_q   <= next_word;
              mem_addr <= {tag_q, idx_q, next_word, 2'b00};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
// Hits return the instruction combinationally; misses stall the fetch
// stage while icache_refill_ctrl fetches the whole line.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_ce_i, cpu_addr_i     fetch request and byte address
//   cpu_data_o, cpu_valid_o  instruction word and hit flag
//   stall_req_o              IF stall request (miss or refill in progress)
//   flush_i                  invalidate every line
//   mem_req_o, mem_addr_o    word read request / word-aligned address
//   mem_data_i, mem_ack_i    read data and same-cycle acknowledge
//   hit_cnt_o, miss_cnt_o    free-running 32-bit hit / miss counters
module icache
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ce_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  output logic [31:0]           cpu_data_o,
  output logic                  cpu_valid_o,
  output logic                  stall_req_o,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_data_i,
  input  logic                  mem_ack_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDR_WIDTH - OFF_BITS - IDX_BITS - 2;

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_mem  [SETS];
  logic [31:0]         data_mem [SETS][LINE_WORDS];

  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] lk_idx;
  logic [OFF_BITS-1:0] lk_off;
  logic                lookup;
  logic                hit_raw;
  logic                hit;
  logic                miss;

  logic                busy;
  logic                wr_en;
  logic                fill_done;
  logic                set_valid;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic [OFF_BITS-1:0] fill_word;

  assign lk_off = OFF_BITS'(addr_field(64'(cpu_addr_i), 2, OFF_BITS));
  assign lk_idx = IDX_BITS'(addr_field(64'(cpu_addr_i), OFF_BITS + 2, IDX_BITS));
  assign lk_tag = TAG_BITS'(addr_field(64'(cpu_addr_i), OFF_BITS + IDX_BITS + 2, TAG_BITS));

  // Lookups only happen in IDLE and out of reset; they see the valid bits
  // from before any flush landing at the end of this cycle.
  assign lookup  = rst && cpu_ce_i && !busy;
  assign hit_raw = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign hit     = lookup && hit_raw;
  assign miss    = lookup && !hit_raw;

  assign cpu_valid_o = hit;
  assign cpu_data_o  = hit ? data_mem[lk_idx][lk_off] : 32'd0;
  assign stall_req_o = busy || miss;

  icache_refill_ctrl #(
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_refill (
    .clk       (clk),
    .rst       (rst),
    .start     (miss),
    .miss_tag  (lk_tag),
    .miss_idx  (lk_idx),
    .flush     (flush_i),
    .mem_ack   (mem_ack_i),
    .busy      (busy),
    .mem_req   (mem_req_o),
    .mem_addr  (mem_addr_o),
    .wr_en     (wr_en),
    .fill_done (fill_done),
    .set_valid (set_valid),
    .fill_idx  (fill_idx),
    .fill_tag  (fill_tag),
    .fill_word (fill_word)
  );

  // Valid bits: a flush wipes everything; otherwise a completed,
  // un-flushed refill marks its line valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[fill_idx][fill_word] <= mem_data_i;
    end
    if (fill_done) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  // Free-running event counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (miss) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed, self-checking bench for icache in its default
// geometry. A behavioural memory answers refills with word = 0xA0000000 ^
// address after a programmable number of wait cycles and logs every
// acknowledged address.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic        cpu_valid_o;
  logic        stall_req_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int          compareCount;
  int          mismatchCount;
  int          ackDelay;
  logic [31:0] logAddr[$];

  icache dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_ce_i    (cpu_ce_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_valid_o (cpu_valid_o),
    .stall_req_o (stall_req_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'hA000_0000 ^ addr;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Memory model: decides ack/data at each falling edge for the next
  // rising edge, and checks the request address holds while waiting.
  initial begin : memModel
    int          waitCnt;
    logic        holding;
    logic [31:0] heldAddr;
    mem_ack_i  = 1'b0;
    mem_data_i = 32'd0;
    waitCnt    = 0;
    holding    = 1'b0;
    heldAddr   = 32'd0;
    forever begin
      @(negedge clk);
      if (!mem_req_o) begin
        mem_ack_i = 1'b0;
        waitCnt   = 0;
        holding   = 1'b0;
      end else if (waitCnt >= ackDelay) begin
        if (holding) checkOutput("addr_hold", mem_addr_o, heldAddr);
        mem_ack_i  = 1'b1;
        mem_data_i = memWord(mem_addr_o);
        logAddr.push_back(mem_addr_o);
        waitCnt    = 0;
        holding    = 1'b0;
      end else begin
        if (holding) checkOutput("addr_hold", mem_addr_o, heldAddr);
        else begin
          holding  = 1'b1;
          heldAddr = mem_addr_o;
        end
        mem_ack_i = 1'b0;
        waitCnt++;
      end
    end
  end

  // Fetch one address (called just after a rising edge): counts stall
  // cycles until the hit and returns the word. Optional flush in cycle 1.
  task automatic applyStimulus(input logic [31:0] addr, input logic doFlush,
                               output int stalls, output logic [31:0] data);
    logic found;
    stalls     = 0;
    data       = 32'd0;
    found      = 1'b0;
    cpu_ce_i   = 1'b1;
    cpu_addr_i = addr;
    flush_i    = doFlush;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk);
      if (cpu_valid_o) begin
        data  = cpu_data_o;
        found = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      flush_i = 1'b0;
    end
    cpu_ce_i = 1'b0;
    if (!found) begin
      stalls = -1;
      $display("[TB] FAIL fetch_timeout: observed no hit, expected hit for %h", addr);
      mismatchCount++;
      compareCount++;
    end
  endtask

  task automatic fetchAndCheck(input string tag, input logic [31:0] addr,
                               input logic doFlush, input int expStalls);
    int          stalls;
    logic [31:0] data;
    applyStimulus(addr, doFlush, stalls, data);
    checkOutput({tag, "_stall"}, 32'(stalls), 32'(expStalls));
    checkOutput({tag, "_data"}, data, memWord(addr));
  endtask

  task automatic waitIdle();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (!stall_req_o) done = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("wait_idle", 32'(done), 32'd1);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    ackDelay      = 0;
    rst           = 1'b0;
    cpu_ce_i      = 1'b0;
    cpu_addr_i    = 32'd0;
    flush_i       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
    checkOutput("rst_valid", 32'(cpu_valid_o), 32'd0);
    checkOutput("rst_data", cpu_data_o, 32'd0);
    checkOutput("rst_stall", 32'(stall_req_o), 32'd0);
    checkOutput("rst_hits", hit_cnt_o, 32'd0);
    checkOutput("rst_misses", miss_cnt_o, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, zero-wait memory
    logAddr.delete();
    fetchAndCheck("cold", 32'h0000_0104, 1'b0, 5);
    checkOutput("cold_nreads", 32'(logAddr.size()), 32'd4);
    for (int i = 0; i < 4 && i < logAddr.size(); i++)
      checkOutput("cold_read_addr", logAddr[i], 32'h100 + 32'(4 * i));
    checkOutput("cold_hits", hit_cnt_o, 32'd1);
    checkOutput("cold_misses", miss_cnt_o, 32'd1);

    // Same line hits without memory traffic; conflicting tag evicts it
    logAddr.delete();
    fetchAndCheck("same_line", 32'h0000_0108, 1'b0, 0);
    checkOutput("same_line_nreads", 32'(logAddr.size()), 32'd0);
    fetchAndCheck("conflict", 32'h0000_0500, 1'b0, 5);
    checkOutput("conflict_nreads", 32'(logAddr.size()), 32'd4);
    if (logAddr.size() == 4) begin
      checkOutput("conflict_first", logAddr[0], 32'h500);
      checkOutput("conflict_last", logAddr[3], 32'h50C);
    end
    fetchAndCheck("evicted", 32'h0000_0104, 1'b0, 5);
    checkOutput("conflict_hits", hit_cnt_o, 32'd4);
    checkOutput("conflict_misses", miss_cnt_o, 32'd3);

    // Three wait states per word: 4 x 4 + 1 stall cycles
    ackDelay = 3;
    logAddr.delete();
    fetchAndCheck("waitst", 32'h0000_0208, 1'b0, 17);
    checkOutput("waitst_nreads", 32'(logAddr.size()), 32'd4);
    ackDelay = 0;

    // Flush in IDLE invalidates the line just filled
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    fetchAndCheck("idle_flush", 32'h0000_0200, 1'b0, 5);
    checkOutput("idle_flush_hits", hit_cnt_o, 32'd6);
    checkOutput("idle_flush_misses", miss_cnt_o, 32'd5);

    // Flush during refill cycle 2: refill completes but line stays invalid
    logAddr.delete();
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_0100;
    @(posedge clk);
    #1;
    cpu_ce_i   = 1'b0;
    cpu_addr_i = 32'h0000_0700;
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    waitIdle();
    checkOutput("rf_flush_nreads", 32'(logAddr.size()), 32'd4);
    if (logAddr.size() == 4) checkOutput("rf_flush_last", logAddr[3], 32'h10C);
    checkOutput("rf_flush_misses", miss_cnt_o, 32'd6);
    fetchAndCheck("rf_flush_refetch", 32'h0000_0100, 1'b0, 5);
    checkOutput("rf_flush_misses2", miss_cnt_o, 32'd7);

    // Flush and hit in the same cycle: hit reported, line gone afterwards
    fetchAndCheck("flush_hit", 32'h0000_0104, 1'b1, 0);
    fetchAndCheck("after_flush_hit", 32'h0000_0108, 1'b0, 5);
    checkOutput("flush_hit_hits", hit_cnt_o, 32'd9);
    checkOutput("flush_hit_misses", miss_cnt_o, 32'd8);

    // Reset after the second ack of a refill
    logAddr.delete();
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_0300;
    @(posedge clk);
    #1;
    cpu_ce_i = 1'b0;
    begin : waitTwoAcks
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 32 && !seen; c++) begin
        @(negedge clk);
        #1;
        if (logAddr.size() >= 2) seen = 1'b1;
      end
      checkOutput("rst_mid_acks", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #2;
    checkOutput("rst_mid_req_before", 32'(mem_req_o), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_req_drop", 32'(mem_req_o), 32'd0);
    checkOutput("rst_mid_stall", 32'(stall_req_o), 32'd0);
    checkOutput("rst_mid_misses", miss_cnt_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    fetchAndCheck("post_rst", 32'h0000_0100, 1'b0, 5);
    checkOutput("post_rst_hits", hit_cnt_o, 32'd1);
    checkOutput("post_rst_misses", miss_cnt_o, 32'd1);

    // ce low: no lookup, no traffic, counters frozen
    logAddr.delete();
    cpu_ce_i   = 1'b0;
    cpu_addr_i = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ce_low_valid", 32'(cpu_valid_o), 32'd0);
      checkOutput("ce_low_data", cpu_data_o, 32'd0);
      checkOutput("ce_low_stall", 32'(stall_req_o), 32'd0);
      @(posedge clk);
      #1;
      cpu_addr_i = 32'h0000_0900 + 32'(16 * i);
    end
    checkOutput("ce_low_nreads", 32'(logAddr.size()), 32'd0);
    checkOutput("ce_low_hits", hit_cnt_o, 32'd1);
    checkOutput("ce_low_misses", miss_cnt_o, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
